// File: rtl/eth_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : eth_frame_scheduler
// Description : Sequences one frame as a train of RMII Ethernet packets:
//               address load, preamble/SFD, gated payload from the dibit
//               datapath, FCS hand-off and inter-packet gap.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_frame_scheduler #(
    parameter int PIXELS_PER_PKT  = 256,
    parameter int FRAME_PIXELS    = 76800,
    parameter int PREAMBLE_DIBITS = 32,
    parameter int IFG_DIBITS      = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    output logic        busy,
    output logic        frame_done,
    output logic        dp_stall,
    output logic        dp_addr_load,
    output logic [23:0] dp_addr_base,
    input  logic        dp_axiov,
    input  logic [1:0]  dp_axiod,
    output logic        crc_start,
    input  logic        crc_done,
    output logic        tx_axiov,
    output logic [1:0]  tx_axiod,
    output logic [15:0] pkt_count
);

    localparam logic [23:0] c_PKT_PIXELS   = 24'(PIXELS_PER_PKT);
    localparam logic [23:0] c_FRAME_PIXELS = 24'(FRAME_PIXELS);
    localparam logic [25:0] c_PRE_LAST     = 26'(PREAMBLE_DIBITS - 1);
    localparam logic [25:0] c_IFG_LAST     = 26'(IFG_DIBITS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_PREAMBLE = 3'd2,
        S_PAYLOAD  = 3'd3,
        S_CRC_WAIT = 3'd4,
        S_IFG      = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [23:0] r_pixel_remaining;
    logic [23:0] r_pkt_pixels;
    logic [23:0] r_addr_base;
    logic [15:0] r_pkt_count;
    logic [25:0] r_cnt;
    logic        r_crc_start;

    logic [25:0] w_cnt_inc;
    logic [25:0] w_pkt_dibits;
    logic [23:0] w_pkt_pixels_nxt;

    // One shared counter serves preamble length, payload dibits and IFG length
    assign w_cnt_inc        = r_cnt + 26'd1;
    assign w_pkt_dibits     = {r_pkt_pixels, 2'b00};
    assign w_pkt_pixels_nxt = (r_pixel_remaining < c_PKT_PIXELS) ? r_pixel_remaining : c_PKT_PIXELS;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; a zero-length frame skips straight to DONE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_state_next = (c_FRAME_PIXELS == 24'd0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD:     w_state_next = S_PREAMBLE;
            S_PREAMBLE: begin
                if (r_cnt == c_PRE_LAST) begin
                    w_state_next = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (dp_axiov && (w_cnt_inc == w_pkt_dibits)) begin
                    w_state_next = S_CRC_WAIT;
                end
            end
            S_CRC_WAIT: begin
                if (crc_done) begin
                    w_state_next = S_IFG;
                end
            end
            S_IFG: begin
                if (r_cnt == c_IFG_LAST) begin
                    w_state_next = (r_pixel_remaining != 24'd0) ? S_LOAD : S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Frame bookkeeping, phase counter and the crc_start entry pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pixel_remaining <= 24'd0;
            r_pkt_pixels      <= 24'd0;
            r_addr_base       <= 24'd0;
            r_pkt_count       <= 16'd0;
            r_cnt             <= 26'd0;
            r_crc_start       <= 1'b0;
        end else begin
            r_crc_start <= (r_state == S_PAYLOAD) && (w_state_next == S_CRC_WAIT);

            if (w_state_next != r_state) begin
                r_cnt <= 26'd0;
            end else begin
                case (r_state)
                    S_PREAMBLE, S_IFG: r_cnt <= w_cnt_inc;
                    S_PAYLOAD: begin
                        if (dp_axiov) begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: r_cnt <= r_cnt;
                endcase
            end

            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_pixel_remaining <= c_FRAME_PIXELS;
                        r_addr_base       <= 24'd0;
                        r_pkt_count       <= 16'd0;
                    end
                end
                S_LOAD: begin
                    r_pkt_pixels <= w_pkt_pixels_nxt;
                end
                S_CRC_WAIT: begin
                    if (crc_done) begin
                        if (r_pkt_count != 16'hFFFF) begin
                            r_pkt_count <= r_pkt_count + 16'd1;
                        end
                        r_addr_base       <= r_addr_base + r_pkt_pixels;
                        r_pixel_remaining <= r_pixel_remaining - r_pkt_pixels;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Transmit mux: own preamble/SFD, datapath pass-through in payload, silent otherwise
    always_comb begin
        tx_axiov = 1'b0;
        tx_axiod = 2'b00;
        case (r_state)
            S_PREAMBLE: begin
                tx_axiov = 1'b1;
                tx_axiod = (r_cnt == c_PRE_LAST) ? 2'b11 : 2'b01;
            end
            S_PAYLOAD: begin
                tx_axiov = dp_axiov;
                tx_axiod = dp_axiod;
            end
            default: begin
            end
        endcase
    end

    assign busy         = (r_state != S_IDLE);
    assign frame_done   = (r_state == S_DONE);
    assign dp_stall     = (r_state != S_PAYLOAD);
    assign dp_addr_load = (r_state == S_LOAD);
    assign dp_addr_base = r_addr_base;
    assign crc_start    = r_crc_start;
    assign pkt_count    = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_eth_frame_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_eth_frame_scheduler
// Description : Self-checking bench for eth_frame_scheduler; randomised
//               datapath/FCS responders, per-frame trace checked against
//               packet arithmetic derived from the frame parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_frame_scheduler;

    localparam int TB_PPP   = 4;
    localparam int TB_FRAME = 10;
    localparam int TB_PRE   = 32;
    localparam int TB_IFG   = 4;
    localparam int TMAX     = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        dp_axiov = 1'b0;
    logic [1:0]  dp_axiod = 2'b00;
    logic        crc_done = 1'b0;
    logic        busy, frame_done, dp_stall, dp_addr_load, crc_start, tx_axiov;
    logic [23:0] dp_addr_base;
    logic [1:0]  tx_axiod;
    logic [15:0] pkt_count;

    // second instance: zero-pixel frame
    logic        z_frame_start = 1'b0;
    logic        z_tie_v = 1'b0;
    logic [1:0]  z_tie_d = 2'b00;
    logic        z_tie_crc = 1'b0;
    logic        z_busy, z_frame_done, z_dp_stall, z_dp_addr_load, z_crc_start, z_tx_axiov;
    logic [23:0] z_dp_addr_base;
    logic [1:0]  z_tx_axiod;
    logic [15:0] z_pkt_count;

    eth_frame_scheduler #(
        .PIXELS_PER_PKT(TB_PPP), .FRAME_PIXELS(TB_FRAME),
        .PREAMBLE_DIBITS(TB_PRE), .IFG_DIBITS(TB_IFG)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .busy(busy),
        .frame_done(frame_done), .dp_stall(dp_stall), .dp_addr_load(dp_addr_load),
        .dp_addr_base(dp_addr_base), .dp_axiov(dp_axiov), .dp_axiod(dp_axiod),
        .crc_start(crc_start), .crc_done(crc_done), .tx_axiov(tx_axiov),
        .tx_axiod(tx_axiod), .pkt_count(pkt_count)
    );

    eth_frame_scheduler #(
        .PIXELS_PER_PKT(TB_PPP), .FRAME_PIXELS(0),
        .PREAMBLE_DIBITS(TB_PRE), .IFG_DIBITS(TB_IFG)
    ) dut_zero (
        .clk(clk), .rst(rst), .frame_start(z_frame_start), .busy(z_busy),
        .frame_done(z_frame_done), .dp_stall(z_dp_stall), .dp_addr_load(z_dp_addr_load),
        .dp_addr_base(z_dp_addr_base), .dp_axiov(z_tie_v), .dp_axiod(z_tie_d),
        .crc_start(z_crc_start), .crc_done(z_tie_crc), .tx_axiov(z_tx_axiov),
        .tx_axiod(z_tx_axiod), .pkt_count(z_pkt_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // responder controls
    int env_lat = 2, env_gap = 0, env_crc_lat = 16;
    bit env_noise = 0, env_inj_fs = 0, env_inj_crc = 0, force_dpv = 0, z_go = 0;
    int run_low = 0, crc_cd = -1, inj_cd = 0;

    // per-cycle trace of one frame
    bit          rec_on = 0;
    int          tlen = 0;
    logic        tr_txv [TMAX];
    logic [1:0]  tr_txd [TMAX];
    logic        tr_dpv [TMAX];
    logic [1:0]  tr_dpd [TMAX];
    logic        tr_load [TMAX];
    logic [23:0] tr_addr [TMAX];
    logic        tr_crcs [TMAX];
    logic        tr_crcd [TMAX];
    logic        tr_fd [TMAX];
    logic        tr_busy [TMAX];
    logic        tr_stall [TMAX];
    logic [15:0] tr_pc [TMAX];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // pixels carried by packet i of a frame
    function automatic int pix_of(input int i);
        int rem;
        rem = TB_FRAME - i * TB_PPP;
        return (rem < TB_PPP) ? rem : TB_PPP;
    endfunction

    // One clock cycle: drive inputs after the edge, then sample outputs
    task automatic step(input logic fs);
        logic v;
        @(posedge clk);
        #1;
        if (!dp_stall) run_low++; else run_low = 0;
        v = 1'b0;
        if (!dp_stall && run_low > env_lat) begin
            case (env_gap)
                0:       v = 1'b1;
                1:       v = ((run_low - env_lat - 1) % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
        end else if (dp_stall && env_noise) begin
            v = 1'($urandom_range(0, 1));
        end
        if (force_dpv) v = 1'b1;
        dp_axiov      = v;
        dp_axiod      = 2'($urandom_range(0, 3));
        frame_start   = fs || (env_inj_fs && run_low == 5);
        z_frame_start = z_go;
        crc_done      = 1'b0;
        if (inj_cd > 0) begin
            inj_cd--;
            if (inj_cd == 0) crc_done = 1'b1;
        end
        if (crc_start) crc_cd = env_crc_lat;
        if (crc_cd == 0) begin
            crc_done = 1'b1;
            crc_cd   = -1;
            if (env_inj_crc) inj_cd = 2;
        end else if (crc_cd > 0) begin
            crc_cd--;
        end
        #1;
        if (rec_on && tlen < TMAX) begin
            tr_txv[tlen]   = tx_axiov;
            tr_txd[tlen]   = tx_axiod;
            tr_dpv[tlen]   = dp_axiov;
            tr_dpd[tlen]   = dp_axiod;
            tr_load[tlen]  = dp_addr_load;
            tr_addr[tlen]  = dp_addr_base;
            tr_crcs[tlen]  = crc_start;
            tr_crcd[tlen]  = crc_done;
            tr_fd[tlen]    = frame_done;
            tr_busy[tlen]  = busy;
            tr_stall[tlen] = dp_stall;
            tr_pc[tlen]    = pkt_count;
            tlen++;
        end
    endtask

    // Check the recorded frame against the packet plan of the frame parameters
    task automatic check_frame(input string nm);
        int n, pos, j, c, cnt, p, nload, ncrcs, nfd;
        n   = (TB_FRAME + TB_PPP - 1) / TB_PPP;
        pos = 1;
        if (tlen > 1) check($sformatf("%s_pc_cleared", nm), tr_pc[1], 0);
        for (int i = 0; i < n; i++) begin
            p = pix_of(i);
            if (pos + TB_PRE >= tlen) begin
                check($sformatf("%s_p%0d_trace_short", nm, i), tlen, pos + TB_PRE + 1);
                break;
            end
            check($sformatf("%s_p%0d_load", nm, i), tr_load[pos], 1);
            check($sformatf("%s_p%0d_addr", nm, i), tr_addr[pos], i * TB_PPP);
            check($sformatf("%s_p%0d_load_txv", nm, i), tr_txv[pos], 0);
            for (int k = 1; k <= TB_PRE; k++) begin
                check($sformatf("%s_p%0d_pre%0d_v", nm, i, k), tr_txv[pos + k], 1);
                check($sformatf("%s_p%0d_pre%0d_d", nm, i, k), tr_txd[pos + k], (k == TB_PRE) ? 3 : 1);
                check($sformatf("%s_p%0d_pre%0d_stall", nm, i, k), tr_stall[pos + k], 1);
            end
            j   = pos + TB_PRE + 1;
            cnt = 0;
            while (cnt < 4 * p && j < tlen) begin
                check($sformatf("%s_p%0d_pl_stall@%0d", nm, i, j), tr_stall[j], 0);
                check($sformatf("%s_p%0d_pl_v@%0d", nm, i, j), tr_txv[j], tr_dpv[j]);
                if (tr_dpv[j]) begin
                    check($sformatf("%s_p%0d_pl_d@%0d", nm, i, j), tr_txd[j], tr_dpd[j]);
                    cnt++;
                end
                j++;
            end
            check($sformatf("%s_p%0d_payload_dibits", nm, i), cnt, 4 * p);
            if (j >= tlen) break;
            check($sformatf("%s_p%0d_crc_start", nm, i), tr_crcs[j], 1);
            c = j;
            while (c < tlen && !tr_crcd[c]) begin
                check($sformatf("%s_p%0d_cw_v@%0d", nm, i, c), tr_txv[c], 0);
                check($sformatf("%s_p%0d_cw_stall@%0d", nm, i, c), tr_stall[c], 1);
                if (c > j) check($sformatf("%s_p%0d_cw_crcs@%0d", nm, i, c), tr_crcs[c], 0);
                c++;
            end
            if (c + TB_IFG + 1 >= tlen) begin
                check($sformatf("%s_p%0d_crc_trace_short", nm, i), tlen, c + TB_IFG + 2);
                break;
            end
            check($sformatf("%s_p%0d_cw_done_v", nm, i), tr_txv[c], 0);
            for (int k = 1; k <= TB_IFG; k++) begin
                check($sformatf("%s_p%0d_ifg%0d_v", nm, i, k), tr_txv[c + k], 0);
                check($sformatf("%s_p%0d_ifg%0d_pc", nm, i, k), tr_pc[c + k], i + 1);
                check($sformatf("%s_p%0d_ifg%0d_load", nm, i, k), tr_load[c + k], 0);
                check($sformatf("%s_p%0d_ifg%0d_busy", nm, i, k), tr_busy[c + k], 1);
            end
            pos = c + TB_IFG + 1;
        end
        if (pos + 1 < tlen) begin
            check($sformatf("%s_frame_done_at_end", nm), tr_fd[pos], 1);
            check($sformatf("%s_busy_at_done", nm), tr_busy[pos], 1);
            check($sformatf("%s_idle_after_done", nm), tr_busy[pos + 1], 0);
            check($sformatf("%s_final_pc", nm), tr_pc[pos + 1], n);
        end else begin
            check($sformatf("%s_end_trace_short", nm), tlen, pos + 2);
        end
        nload = 0; ncrcs = 0; nfd = 0;
        for (int k = 0; k < tlen; k++) begin
            if (tr_load[k] === 1'b1) nload++;
            if (tr_crcs[k] === 1'b1) ncrcs++;
            if (tr_fd[k] === 1'b1)   nfd++;
        end
        check($sformatf("%s_num_loads", nm), nload, n);
        check($sformatf("%s_num_crc_start", nm), ncrcs, n);
        check($sformatf("%s_num_frame_done", nm), nfd, 1);
    endtask

    // Launch a frame from IDLE, record until frame_done (bounded), then check
    task automatic run_frame(input string nm);
        bit seen;
        crc_cd = -1;
        inj_cd = 0;
        tlen   = 0;
        rec_on = 1;
        seen   = 0;
        step(1'b1);
        for (int k = 0; k < TMAX - 4 && !seen; k++) begin
            step(1'b0);
            if (frame_done) seen = 1;
        end
        step(1'b0);
        step(1'b0);
        rec_on = 0;
        check($sformatf("%s_frame_done_seen", nm), seen, 1);
        check_frame(nm);
    endtask

    initial begin
        bit reached;
        int loads;

        // reset values
        rst = 1'b1;
        step(1'b0);
        step(1'b0);
        check("rst_busy", busy, 0);
        check("rst_stall", dp_stall, 1);
        check("rst_txv", tx_axiov, 0);
        check("rst_load", dp_addr_load, 0);
        check("rst_addr", dp_addr_base, 0);
        check("rst_crc_start", crc_start, 0);
        check("rst_pc", pkt_count, 0);
        check("rst_fd", frame_done, 0);
        check("z_rst_busy", z_busy, 0);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0);
            check("idle_stall", dp_stall, 1);
            check("idle_txv", tx_axiov, 0);
            check("idle_busy", busy, 0);
            check("idle_fd", frame_done, 0);
        end

        // basic frame: 2-cycle datapath latency, FCS 16 cycles after crc_start
        env_lat = 2; env_gap = 0; env_crc_lat = 16; env_noise = 0; env_inj_fs = 0; env_inj_crc = 0;
        run_frame("basic");

        // alternating valid during payload
        env_gap = 1;
        run_frame("gapped");

        // mid-payload frame_start and IFG crc_done must be ignored
        env_gap = 0; env_lat = 1; env_crc_lat = 5; env_inj_fs = 1; env_inj_crc = 1;
        run_frame("ignored_inputs");

        // crc_done coincident with crc_start, zero datapath latency, stray datapath valids
        env_lat = 0; env_crc_lat = 0; env_inj_fs = 0; env_inj_crc = 0; env_noise = 1;
        run_frame("crc_coincident");

        // randomised frames
        for (int r = 0; r < 4; r++) begin
            env_lat     = $urandom_range(0, 6);
            env_gap     = $urandom_range(0, 2);
            env_crc_lat = $urandom_range(0, 20);
            env_noise   = 1'($urandom_range(0, 1));
            env_inj_fs  = 1'($urandom_range(0, 1));
            env_inj_crc = 1'($urandom_range(0, 1));
            run_frame($sformatf("rand%0d", r));
        end

        // reset during the second packet's payload
        env_lat = 2; env_gap = 0; env_crc_lat = 16; env_noise = 0; env_inj_fs = 0; env_inj_crc = 0;
        crc_cd = -1; inj_cd = 0;
        loads = 0; reached = 0;
        step(1'b1);
        for (int k = 0; k < 600 && !reached; k++) begin
            step(1'b0);
            if (dp_addr_load) loads++;
            if (loads == 2 && dp_axiov && !dp_stall) reached = 1;
        end
        check("abort_reached_pkt2_payload", reached, 1);
        rst = 1'b1;
        force_dpv = 1;
        step(1'b0);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_stall", dp_stall, 1);
        check("abort_txv", tx_axiov, 0);
        check("abort_pc", pkt_count, 0);
        check("abort_fd", frame_done, 0);
        check("abort_addr", dp_addr_base, 0);
        force_dpv = 0;
        crc_cd = -1;
        for (int k = 0; k < 10; k++) begin
            step(1'b0);
            check("abort_idle_fd", frame_done, 0);
            check("abort_idle_busy", busy, 0);
        end
        run_frame("restart");

        // zero-pixel frame goes straight to DONE
        z_go = 1;
        step(1'b0);
        z_go = 0;
        step(1'b0);
        check("zero_fd", z_frame_done, 1);
        check("zero_busy", z_busy, 1);
        check("zero_load", z_dp_addr_load, 0);
        check("zero_txv", z_tx_axiov, 0);
        step(1'b0);
        check("zero_fd_after", z_frame_done, 0);
        check("zero_busy_after", z_busy, 0);
        check("zero_pc", z_pkt_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eth_frame_scheduler.md
Name: eth_frame_scheduler

Overview:
- Sequences the RMII transmit path that sends one camera/lightboard frame from FPGA1 as a train of Ethernet packets.
- Per packet it:
  - loads the pixel base address into the bit-order/dibit datapath;
  - emits preamble + SFD dibits itself;
  - un-stalls the datapath for exactly one packet's worth of pixel dibits;
  - hands off to the FCS (CRC) appender;
  - enforces the inter-packet gap.
- Sits between the frame-buffer read side and the RMII output mux.

Parameters:
- PIXELS_PER_PKT, 256, pixels carried per packet payload (each pixel = 4 dibits).
- FRAME_PIXELS, 76800, pixels per frame; the last packet carries the remainder if not a multiple.
- PREAMBLE_DIBITS, 32, preamble + SFD length in dibits (7×0x55 + 0xD5).
- IFG_DIBITS, 48, inter-packet gap in clock cycles (96 bit times).

Ports:
- clk  in  1  50 MHz RMII reference clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  single-cycle request to transmit one frame; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last packet's IFG completes.
- dp_stall  out  1  stall to the bit-order datapath; low only in PAYLOAD.
- dp_addr_load  out  1  one-cycle pulse; datapath loads dp_addr_base as its next pixel address.
- dp_addr_base  out  24  first pixel index of the upcoming packet.
- dp_axiov  in  1  datapath dibit valid.
- dp_axiod  in  2  datapath dibit.
- crc_start  out  1  one-cycle pulse on entry to CRC_WAIT.
- crc_done  in  1  FCS appender finished emitting 32-bit FCS.
- tx_axiov  out  1  dibit valid to RMII mux.
- tx_axiod  out  2  dibit to RMII mux.
- pkt_count  out  16  packets completed in current frame; cleared on frame_start accept.

Behaviour:

Reset values:
- State IDLE.
- All outputs 0 except dp_stall = 1.
- Internal counters 0.
- Reset asserted mid-frame aborts immediately: no frame_done, and tx_axiov = 0 in the cycle after rst.

State machine (registered outputs unless noted):
- IDLE:
  - On frame_start, go to LOAD.
  - pixel_remaining <= FRAME_PIXELS, dp_addr_base <= 0, pkt_count <= 0.
  - frame_start in any other state is ignored.
- LOAD (1 cycle):
  - dp_addr_load = 1.
  - pkt_pixels = min(PIXELS_PER_PKT, pixel_remaining).
  - Next state PREAMBLE.
- PREAMBLE (PREAMBLE_DIBITS cycles):
  - tx_axiov = 1.
  - tx_axiod = 2'b01 for the first PREAMBLE_DIBITS-1 cycles, then 2'b11 on the final cycle (SFD 0xD5 LSB-first).
  - Next state PAYLOAD.
- PAYLOAD:
  - dp_stall = 0.
  - tx_axiov/tx_axiod = dp_axiov/dp_axiod, combinational pass-through.
  - Count only cycles with dp_axiov = 1.
  - In the cycle the count reaches pkt_pixels×4, go to CRC_WAIT; dp_stall is 1 from the next cycle.
  - Datapath latency before the first valid is tolerated with no limit.
- CRC_WAIT:
  - crc_start pulses on the entry cycle.
  - tx_axiov = 0; the FCS block drives the downstream mux.
  - Valid dibits from the datapath here are dropped.
  - On crc_done: pkt_count += 1, dp_addr_base += pkt_pixels, pixel_remaining -= pkt_pixels, go to IFG.
- IFG (IFG_DIBITS cycles):
  - tx_axiov = 0.
  - Then LOAD if pixel_remaining ≠ 0, else DONE.
- DONE (1 cycle):
  - frame_done = 1.
  - Next state IDLE.

Boundary and width rules:
- crc_done outside CRC_WAIT is ignored.
- crc_done coinciding with crc_start is accepted.
- FRAME_PIXELS < PIXELS_PER_PKT gives a single short packet.
- FRAME_PIXELS = 0 goes IDLE → DONE directly, with no packet.
- Address and remaining-pixel arithmetic is 24-bit unsigned; no wrap within a frame.
- pkt_count saturates at 0xFFFF.

Test Plan (PIXELS_PER_PKT=4, FRAME_PIXELS=10, PREAMBLE_DIBITS=32, IFG_DIBITS=4 unless noted):
- Reset then idle 10 cycles → dp_stall=1, tx_axiov=0, busy=0, frame_done never pulses.
- frame_start; datapath returns 16 valid dibits 2 cycles after stall drops; crc_done 16 cycles after crc_start → packet 1:
  - dp_addr_base=0.
  - 31×01 then 11 on tx_axiod.
  - Exactly 16 payload dibits passed through.
  - One crc_start.
  - pkt_count=1.
- Full frame → three packets:
  - dp_addr_base = 0, 4, 8.
  - Payload dibit counts 16, 16, 8.
  - frame_done pulses once, 1 cycle after the third IFG ends.
  - pkt_count=3.
- dp_axiov gapped (alternating 1/0) during PAYLOAD → CRC_WAIT is entered only after 16 valid dibits; invalid cycles give tx_axiov=0.
- frame_start asserted mid-PAYLOAD and crc_done pulsed during IFG → both ignored; packet sequence unchanged.
- rst asserted during second packet's PAYLOAD → next cycle IDLE, dp_stall=1, tx_axiov=0, pkt_count=0; a new frame_start restarts at dp_addr_base=0.
